// File: rtl/mw_pkg.sv
// mw_pkg: shared state encoding, stage entry type and time limits for microwave_sequencer
package mw_pkg;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 99;
  localparam int PWR_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} mw_state_e;
  typedef struct packed {
    logic [6:0]       min;
    logic [5:0]       sec;
    logic [PWR_W-1:0] pwr;
  } stage_t;
endpackage

// File: rtl/mw_if.sv
// mw_if: program entry, buttons/sensors in; state, stage, remaining time, magnetron and buzzer out
// master: keypad/program side (drives prog_*, start_stop, cancel, door_open); slave: sequencer
// MW_CHILD_LOCK_EN adds the locked status output
interface mw_if #(parameter int NUM_STAGES = 4, parameter int POWER_MAX = 10);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam int CW = $clog2(NUM_STAGES + 1);
  localparam int PW = $clog2(POWER_MAX + 1);
  logic          prog_we;
  logic [IW-1:0] prog_idx;
  logic [6:0]    prog_min;
  logic [5:0]    prog_sec;
  logic [PW-1:0] prog_pwr;
  logic [CW-1:0] prog_count;
  logic          start_stop, cancel, door_open;
  logic [1:0]    state_o;
  logic [IW-1:0] stage_idx;
  logic [6:0]    rem_min;
  logic [5:0]    rem_sec;
  logic          mag_control, buzzer;
`ifdef MW_CHILD_LOCK_EN
  logic          locked;
  modport master(output prog_we, prog_idx, prog_min, prog_sec, prog_pwr, prog_count, start_stop, cancel, door_open,
                 input state_o, stage_idx, rem_min, rem_sec, mag_control, buzzer, locked);
  modport slave(input prog_we, prog_idx, prog_min, prog_sec, prog_pwr, prog_count, start_stop, cancel, door_open,
                output state_o, stage_idx, rem_min, rem_sec, mag_control, buzzer, locked);
`else
  modport master(output prog_we, prog_idx, prog_min, prog_sec, prog_pwr, prog_count, start_stop, cancel, door_open,
                 input state_o, stage_idx, rem_min, rem_sec, mag_control, buzzer);
  modport slave(input prog_we, prog_idx, prog_min, prog_sec, prog_pwr, prog_count, start_stop, cancel, door_open,
                output state_o, stage_idx, rem_min, rem_sec, mag_control, buzzer);
`endif
endinterface

// File: rtl/mw_tick_gen.sv
// mw_tick_gen: prescaler emitting a 1-cycle tick every DIV enabled cycles; clr zeroes the phase
// ports: clk, rst (async active-low), en, clr -> tick
module mw_tick_gen #(parameter int DIV = 50_000_000) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en & ~clr & (cnt_q == W'(DIV - 1));
  always_comb cnt_d = (clr | tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/microwave_sequencer.sv
// microwave_sequencer: multi-stage cook sequencer with duty-cycled magnetron, door interlock and end buzzer
// ports: clk, rst (async active-low), bus (mw_if.slave); MW_CHILD_LOCK_EN enables the start-hold child lock
module microwave_sequencer
  import mw_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int POWER_MAX  = 10,
  parameter int BEEP_COUNT = 3
) (
  input logic clk,
  input logic rst,
  mw_if.slave bus
);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam int CW = $clog2(NUM_STAGES + 1);
  localparam int PW = $clog2(POWER_MAX + 1);
  localparam int BW = $clog2(2 * BEEP_COUNT + 1);
  mw_state_e     state_q, state_d;
  stage_t        ram_q [NUM_STAGES];
  stage_t        ram_d [NUM_STAGES];
  logic [IW-1:0] idx_q, idx_d, nxt_idx;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] duty_q, duty_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          start_q, start_edge, rem_nz, last, run_go, to_done, tick_en, tick_clr, tick, lock;
  assign start_edge = bus.start_stop & ~start_q;
  assign rem_nz     = |{min_q, sec_q};
  assign last       = CW'(idx_q) + CW'(1) >= count_q;
  assign nxt_idx    = idx_q + 1'b1;
  // prescaler freezes while door/start pre-empt the tick and during 00:00 advance cycles
  assign run_go     = (state_q == RUN) & ~bus.door_open & ~start_edge & rem_nz;
  assign to_done    = (state_q == RUN) & ~bus.door_open & ~start_edge & ~rem_nz & last;
`ifdef MW_CHILD_LOCK_EN
  logic       lock_q, lock_d;
  logic [1:0] hold_q, hold_d;
  assign lock       = lock_q;
  assign bus.locked = lock_q;
  // in IDLE the prescaler times how long start_stop is held; the press edge restarts the phase
  assign tick_en    = run_go | (state_q == DONE) | ((state_q == IDLE) & bus.start_stop);
  assign tick_clr   = bus.cancel | to_done | ((state_q == IDLE) & (~bus.start_stop | start_edge));
  always_comb begin
    hold_d = ((state_q == IDLE) & bus.start_stop & ~bus.cancel) ? hold_q + ((tick & (hold_q != 2'd3)) ? 2'd1 : 2'd0) : 2'd0;
    lock_d = lock_q ^ ((state_q == IDLE) & tick & (hold_q == 2'd2));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lock_q <= 1'b0;
      hold_q <= '0;
    end else begin
      lock_q <= lock_d;
      hold_q <= hold_d;
    end
`else
  assign lock     = 1'b0;
  assign tick_en  = run_go | (state_q == DONE);
  assign tick_clr = bus.cancel | to_done | (state_q == IDLE);
`endif
  mw_tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .en(tick_en), .clr(tick_clr), .tick(tick));
  always_comb begin
    state_d = state_q;
    ram_d   = ram_q;
    idx_d   = idx_q;
    count_d = count_q;
    min_d   = min_q;
    sec_d   = sec_q;
    duty_d  = duty_q;
    beep_d  = beep_q;
    if (bus.cancel) state_d = IDLE;
    else case (state_q)
      IDLE: begin
        idx_d = '0;
        min_d = ram_q[0].min;
        sec_d = ram_q[0].sec;
        if (bus.prog_we & ~lock)
          ram_d[bus.prog_idx] = '{min: (bus.prog_min > 7'(MIN_MAX)) ? 7'(MIN_MAX) : bus.prog_min,
                                  sec: (bus.prog_sec > 6'(SEC_MAX)) ? 6'(SEC_MAX) : bus.prog_sec,
                                  pwr: PWR_W'(bus.prog_pwr)};
        if (start_edge & ~lock & ~bus.door_open & (bus.prog_count != '0) & (bus.prog_count <= CW'(NUM_STAGES))) begin
          state_d = RUN;
          count_d = bus.prog_count;
          duty_d  = '0;
        end
      end
      RUN:
        if (bus.door_open | start_edge) state_d = PAUSE;
        else if (!rem_nz) begin
          if (last) begin
            state_d = DONE;
            beep_d  = '0;
          end else begin
            idx_d  = nxt_idx;
            min_d  = ram_q[nxt_idx].min;
            sec_d  = ram_q[nxt_idx].sec;
            duty_d = '0;
          end
        end else if (tick) begin
          duty_d = (duty_q == PW'(POWER_MAX - 1)) ? '0 : duty_q + 1'b1;
          min_d  = (sec_q == '0) ? min_q - 1'b1 : min_q;
          sec_d  = (sec_q == '0) ? 6'(SEC_MAX) : sec_q - 1'b1;
        end
      PAUSE:
        if (start_edge & ~bus.door_open) state_d = RUN;
      default:
        if (start_edge | bus.door_open) state_d = IDLE;
        else if (tick) begin
          beep_d = beep_q + 1'b1;
          if (beep_q == BW'(2 * BEEP_COUNT - 1)) state_d = IDLE;
        end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      ram_q   <= '{default: '0};
      idx_q   <= '0;
      count_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      duty_q  <= '0;
      beep_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ram_q   <= ram_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      duty_q  <= duty_d;
      beep_q  <= beep_d;
      start_q <= bus.start_stop;
    end
  assign bus.state_o     = state_q;
  assign bus.stage_idx   = idx_q;
  assign bus.rem_min     = min_q;
  assign bus.rem_sec     = sec_q;
  // door_open enters combinationally so the magnetron drops in the same cycle
  assign bus.mag_control = (state_q == RUN) & (PWR_W'(duty_q) < ram_q[idx_q].pwr) & ~bus.door_open;
  assign bus.buzzer      = (state_q == DONE) & ~beep_q[0];
endmodule

// File: tb/tb_microwave_sequencer.sv
// tb_microwave_sequencer: self-checking bench for microwave_sequencer (TICK_DIV=4, 4 stages, 3 beeps)
module tb_microwave_sequencer;
  typedef struct {int at; logic [18:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  mw_if #(.NUM_STAGES(4), .POWER_MAX(10)) bus ();
  microwave_sequencer #(.NUM_STAGES(4), .TICK_DIV(4), .POWER_MAX(10), .BEEP_COUNT(3))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [18:0] pk(int st, int idx, int mn, int sc, int mag, int buz);
    return {2'(st), 2'(idx), 7'(mn), 6'(sc), 1'(mag), 1'(buz)};
  endfunction
  function automatic logic [18:0] snap();
    return {bus.state_o, bus.stage_idx, bus.rem_min, bus.rem_sec, bus.mag_control, bus.buzzer};
  endfunction
  task automatic prog(int idx, int mn, int sc, int pw);
    bus.prog_we = 1'b1;
    bus.prog_idx = 2'(idx);
    bus.prog_min = 7'(mn);
    bus.prog_sec = 6'(sc);
    bus.prog_pwr = 4'(pw);
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask
  task automatic press();
    bus.start_stop = 1'b1;
    @(negedge clk);
    bus.start_stop = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (snap() !== pk(0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_hold got=%h want=%h", snap(), pk(0, 0, 0, 0, 0, 0)); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (snap() !== pk(0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_release got=%h want=%h", snap(), pk(0, 0, 0, 0, 0, 0)); end
  endtask
  task automatic test_bad_count();
    prog(0, 0, 5, 10);
    bus.prog_count = 3'd0;
    press();
    total++;
    if (bus.state_o !== 2'd0) begin bad++; $display("FAIL count0 state=%0d want=0", bus.state_o); end
    bus.prog_count = 3'd5;
    press();
    total++;
    if (bus.state_o !== 2'd0) begin bad++; $display("FAIL count5 state=%0d want=0", bus.state_o); end
    bus.prog_count = 3'd1;
    bus.door_open = 1'b1;
    press();
    bus.door_open = 1'b0;
    total++;
    if (snap() !== pk(0, 0, 0, 5, 0, 0)) begin bad++; $display("FAIL door_start got=%h want=%h", snap(), pk(0, 0, 0, 5, 0, 0)); end
  endtask
  task automatic test_single_stage();
    exp_t e;
    prog(0, 0, 3, 10);
    bus.prog_count = 3'd1;
    press();
    sb.push_back('{0, pk(1, 0, 0, 3, 1, 0)});
    sb.push_back('{3, pk(1, 0, 0, 3, 1, 0)});
    sb.push_back('{4, pk(1, 0, 0, 2, 1, 0)});
    sb.push_back('{8, pk(1, 0, 0, 1, 1, 0)});
    sb.push_back('{12, pk(1, 0, 0, 0, 1, 0)});
    sb.push_back('{13, pk(3, 0, 0, 0, 0, 1)});
    sb.push_back('{16, pk(3, 0, 0, 0, 0, 1)});
    sb.push_back('{17, pk(3, 0, 0, 0, 0, 0)});
    sb.push_back('{21, pk(3, 0, 0, 0, 0, 1)});
    sb.push_back('{25, pk(3, 0, 0, 0, 0, 0)});
    sb.push_back('{29, pk(3, 0, 0, 0, 0, 1)});
    sb.push_back('{33, pk(3, 0, 0, 0, 0, 0)});
    sb.push_back('{36, pk(3, 0, 0, 0, 0, 0)});
    sb.push_back('{37, pk(0, 0, 0, 0, 0, 0)});
    sb.push_back('{38, pk(0, 0, 0, 3, 0, 0)});
    for (int n = 0; n <= 300 && sb.size() > 0; n++) begin
      if (n > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].at == n) begin
        e = sb.pop_front();
        total++;
        if (snap() !== e.v) begin bad++; $display("FAIL single n=%0d got=%h want=%h", n, snap(), e.v); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL single timeout left=%0d", sb.size()); sb.delete(); end
  endtask
  task automatic test_duty();
    exp_t e;
    prog(0, 1, 0, 4);
    bus.prog_count = 3'd1;
    press();
    sb.push_back('{0, pk(1, 0, 1, 0, 1, 0)});
    sb.push_back('{4, pk(1, 0, 0, 59, 1, 0)});
    sb.push_back('{15, pk(1, 0, 0, 57, 1, 0)});
    sb.push_back('{16, pk(1, 0, 0, 56, 0, 0)});
    sb.push_back('{39, pk(1, 0, 0, 51, 0, 0)});
    sb.push_back('{40, pk(1, 0, 0, 50, 1, 0)});
    for (int n = 0; n <= 300 && sb.size() > 0; n++) begin
      if (n > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].at == n) begin
        e = sb.pop_front();
        total++;
        if (snap() !== e.v) begin bad++; $display("FAIL duty n=%0d got=%h want=%h", n, snap(), e.v); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL duty timeout left=%0d", sb.size()); sb.delete(); end
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    total++;
    if ({bus.state_o, bus.mag_control} !== 3'b000) begin bad++; $display("FAIL cancel_run state=%0d mag=%b want 0/0", bus.state_o, bus.mag_control); end
  endtask
  task automatic test_multi_stage();
    exp_t e;
    prog(0, 0, 2, 10);
    prog(1, 0, 0, 0);
    prog(2, 0, 2, 0);
    bus.prog_count = 3'd3;
    press();
    sb.push_back('{0, pk(1, 0, 0, 2, 1, 0)});
    sb.push_back('{8, pk(1, 0, 0, 0, 1, 0)});
    sb.push_back('{9, pk(1, 1, 0, 0, 0, 0)});
    sb.push_back('{10, pk(1, 2, 0, 2, 0, 0)});
    sb.push_back('{13, pk(1, 2, 0, 2, 0, 0)});
    sb.push_back('{14, pk(1, 2, 0, 1, 0, 0)});
    sb.push_back('{18, pk(1, 2, 0, 0, 0, 0)});
    sb.push_back('{19, pk(3, 2, 0, 0, 0, 1)});
    for (int n = 0; n <= 300 && sb.size() > 0; n++) begin
      if (n > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].at == n) begin
        e = sb.pop_front();
        total++;
        if (snap() !== e.v) begin bad++; $display("FAIL multi n=%0d got=%h want=%h", n, snap(), e.v); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL multi timeout left=%0d", sb.size()); sb.delete(); end
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    total++;
    if ({bus.state_o, bus.buzzer} !== 3'b000) begin bad++; $display("FAIL cancel_done state=%0d buz=%b want 0/0", bus.state_o, bus.buzzer); end
  endtask
  task automatic test_door_pause();
    exp_t e;
    prog(0, 0, 5, 10);
    bus.prog_count = 3'd1;
    press();
    sb.push_back('{0, pk(1, 0, 0, 5, 1, 0)});
    sb.push_back('{3, pk(1, 0, 0, 5, 1, 0)});
    for (int n = 0; n <= 300 && sb.size() > 0; n++) begin
      if (n > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].at == n) begin
        e = sb.pop_front();
        total++;
        if (snap() !== e.v) begin bad++; $display("FAIL door n=%0d got=%h want=%h", n, snap(), e.v); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL door timeout left=%0d", sb.size()); sb.delete(); end
    bus.door_open = 1'b1;
    #1;
    total++;
    if (snap() !== pk(1, 0, 0, 5, 0, 0)) begin bad++; $display("FAIL door_comb got=%h want=%h", snap(), pk(1, 0, 0, 5, 0, 0)); end
    @(negedge clk);
    total++;
    if (snap() !== pk(2, 0, 0, 5, 0, 0)) begin bad++; $display("FAIL door_pause got=%h want=%h", snap(), pk(2, 0, 0, 5, 0, 0)); end
    repeat (5) @(negedge clk);
    press();
    total++;
    if (snap() !== pk(2, 0, 0, 5, 0, 0)) begin bad++; $display("FAIL door_open_start got=%h want=%h", snap(), pk(2, 0, 0, 5, 0, 0)); end
    bus.door_open = 1'b0;
    @(negedge clk);
    press();
    total++;
    if (snap() !== pk(1, 0, 0, 5, 1, 0)) begin bad++; $display("FAIL resume got=%h want=%h", snap(), pk(1, 0, 0, 5, 1, 0)); end
    @(negedge clk);
    total++;
    if (snap() !== pk(1, 0, 0, 4, 1, 0)) begin bad++; $display("FAIL resume_phase got=%h want=%h", snap(), pk(1, 0, 0, 4, 1, 0)); end
    repeat (4) @(negedge clk);
    total++;
    if (snap() !== pk(1, 0, 0, 3, 1, 0)) begin bad++; $display("FAIL resume_tick got=%h want=%h", snap(), pk(1, 0, 0, 3, 1, 0)); end
    bus.door_open = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.door_open = 1'b0;
    total++;
    if ({bus.state_o, bus.buzzer, bus.mag_control} !== 4'b0000) begin bad++; $display("FAIL cancel_pause state=%0d buz=%b mag=%b want 0/0/0", bus.state_o, bus.buzzer, bus.mag_control); end
  endtask
  task automatic test_async_reset();
    prog(0, 0, 9, 10);
    bus.prog_count = 3'd1;
    press();
    repeat (5) @(negedge clk);
    total++;
    if (snap() !== pk(1, 0, 0, 8, 1, 0)) begin bad++; $display("FAIL pre_reset got=%h want=%h", snap(), pk(1, 0, 0, 8, 1, 0)); end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (snap() !== pk(0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL async_reset got=%h want=%h", snap(), pk(0, 0, 0, 0, 0, 0)); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (snap() !== pk(0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL ram_cleared got=%h want=%h", snap(), pk(0, 0, 0, 0, 0, 0)); end
  endtask
`ifdef MW_CHILD_LOCK_EN
  task automatic test_child_lock();
    prog(0, 0, 5, 10);
    bus.prog_count = 3'd0;
    bus.start_stop = 1'b1;
    repeat (14) @(negedge clk);
    bus.start_stop = 1'b0;
    total++;
    if (bus.locked !== 1'b1) begin bad++; $display("FAIL lock_on locked=%b want=1", bus.locked); end
    prog(0, 0, 7, 10);
    @(negedge clk);
    total++;
    if (bus.rem_sec !== 6'd5) begin bad++; $display("FAIL lock_we sec=%0d want=5", bus.rem_sec); end
    bus.prog_count = 3'd1;
    press();
    @(negedge clk);
    total++;
    if (bus.state_o !== 2'd0) begin bad++; $display("FAIL lock_start state=%0d want=0", bus.state_o); end
    bus.prog_count = 3'd0;
    bus.start_stop = 1'b1;
    repeat (14) @(negedge clk);
    bus.start_stop = 1'b0;
    total++;
    if (bus.locked !== 1'b0) begin bad++; $display("FAIL lock_off locked=%b want=0", bus.locked); end
  endtask
`endif
  initial begin
    bus.prog_we = 1'b0;
    bus.prog_idx = '0;
    bus.prog_min = '0;
    bus.prog_sec = '0;
    bus.prog_pwr = '0;
    bus.prog_count = '0;
    bus.start_stop = 1'b0;
    bus.cancel = 1'b0;
    bus.door_open = 1'b0;
    test_reset();
    test_bad_count();
    test_single_stage();
    test_duty();
    test_multi_stage();
    test_door_pause();
    test_async_reset();
`ifdef MW_CHILD_LOCK_EN
    test_child_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
